bn_param_loader: RTL and testbench

Serial configuration front-end that writes per-neuron batch-normalization parameters, factor code and signed addend, into a small register table. The table's combinational read port drives the BN_factor and BN_addend inputs of the batch-normalization datapath. The loader rejects any parameter pair that the datapath cannot represent: invalid factor codes, and factor x8 with a non-zero addend. The table therefore never holds an illegal combination.

---
 rtl/bn_pkg.sv | 40 ++++
 rtl/bn_param_loader_if.sv | 39 +++
 rtl/bn_param_table.sv | 40 ++++
 rtl/bn_param_loader.sv | 122 ++++++++++++
 tb/tb_bn_param_loader.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bn_pkg.sv
// Batch-norm parameter codes, loader FSM states
// and the legality check shared with the datapath.
package bn_pkg;

  localparam logic [3:0] BN_X1 = 4'b0100;
  localparam logic [3:0] BN_X8 = 4'b0011;
  localparam logic [3:0] BN_IDENTITY = BN_X1;

  localparam logic [3:0] BN_INV0 = 4'b0000;
  localparam logic [3:0] BN_INV1 = 4'b0111;
  localparam logic [3:0] BN_INV2 = 4'b1011;
  localparam logic [3:0] BN_INV3 = 4'b1111;

  // Widest addend the check accepts; callers
  // zero-extend, only "is zero" matters here.
  localparam int BN_MAX_ADDEND_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CHECK,
    ST_WAIT_LOW
  } bn_state_t;

  function automatic logic bn_param_valid(
    input logic [3:0] factor,
    input logic [BN_MAX_ADDEND_W-1:0] addend
  );
    logic ok;
    ok = 1'b1;
    case (factor)
      BN_INV0, BN_INV1,
      BN_INV2, BN_INV3: ok = 1'b0;
      BN_X8: ok = (addend == '0);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/bn_param_loader_if.sv
// Serial load strobe/data, table read port
// and loader status for bn_param_loader.
interface bn_param_loader_if #(
  parameter int ADDR_WIDTH = 2,
  parameter int ADDEND_WIDTH = 5
);

  logic load_en;
  logic load_data;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [3:0] bn_factor;
  logic [ADDEND_WIDTH-1:0] bn_addend;
  logic busy;
  logic load_done;
  logic load_error;

  modport master (
    output load_en,
    output load_data,
    output rd_addr,
    input bn_factor,
    input bn_addend,
    input busy,
    input load_done,
    input load_error
  );

  modport slave (
    input load_en,
    input load_data,
    input rd_addr,
    output bn_factor,
    output bn_addend,
    output busy,
    output load_done,
    output load_error
  );

endinterface

// File: rtl/bn_param_table.sv
// Per-neuron factor/addend registers, reset to
// identity, one write port, combinational read.
module bn_param_table
  import bn_pkg::*;
#(
  parameter int NEURONS = 4,
  parameter int ADDR_WIDTH = 2,
  parameter int ADDEND_WIDTH = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [3:0] i_wfactor,
  input  logic [ADDEND_WIDTH-1:0] i_waddend,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [3:0] o_rfactor,
  output logic [ADDEND_WIDTH-1:0] o_raddend
);

  logic [3:0] r_factor [NEURONS];
  logic [ADDEND_WIDTH-1:0] r_addend [NEURONS];

  // Entry storage; reset restores x1 pass-through.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NEURONS; i++) begin
        r_factor[i] <= BN_IDENTITY;
        r_addend[i] <= '0;
      end
    end else if (i_we) begin
      r_factor[i_waddr] <= i_wfactor;
      r_addend[i_waddr] <= i_waddend;
    end
  end

  assign o_rfactor = r_factor[i_raddr];
  assign o_raddend = r_addend[i_raddr];

endmodule

// File: rtl/bn_param_loader.sv
// Serial frame receiver: shifts addr/factor/addend
// in MSB-first, commits only legal pairs to the table.
module bn_param_loader
  import bn_pkg::*;
#(
  parameter int NEURONS = 4,
  parameter int ADDR_WIDTH = 2,
  parameter int ADDEND_WIDTH = 5
) (
  input logic clk,
  input logic reset,
  bn_param_loader_if.slave bus
);

  localparam int FRAME_LEN = ADDR_WIDTH + 4 + ADDEND_WIDTH;
  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  bn_state_t r_state;
  bn_state_t w_state_nxt;
  logic [FRAME_LEN-1:0] r_shift;
  logic [FRAME_LEN-1:0] w_shift_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic r_done;
  logic r_err;
  logic w_done_nxt;
  logic w_err_nxt;
  logic w_we;
  logic w_valid;

  logic [ADDR_WIDTH-1:0] w_addr;
  logic [3:0] w_factor;
  logic [ADDEND_WIDTH-1:0] w_addend;

  assign w_addr = r_shift[FRAME_LEN-1 -: ADDR_WIDTH];
  assign w_factor = r_shift[ADDEND_WIDTH +: 4];
  assign w_addend = r_shift[ADDEND_WIDTH-1:0];
  assign w_valid = bn_param_valid(
    w_factor, BN_MAX_ADDEND_W'(w_addend));

  // State, shifter, bit count and status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_cnt <= '0;
      r_done <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt <= w_cnt_nxt;
      r_done <= w_done_nxt;
      r_err <= w_err_nxt;
    end
  end

  // Next-state, shift/count update and commit decision.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt = r_cnt;
    w_done_nxt = 1'b0;
    w_err_nxt = 1'b0;
    w_we = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.load_en) begin
          w_shift_nxt = {{(FRAME_LEN-1){1'b0}}, bus.load_data};
          w_cnt_nxt = CNT_W'(1);
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bus.load_en) begin
          w_shift_nxt = {r_shift[FRAME_LEN-2:0], bus.load_data};
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == CNT_W'(FRAME_LEN - 1))
            w_state_nxt = ST_CHECK;
        end else begin
          w_shift_nxt = '0;
          w_cnt_nxt = '0;
          w_err_nxt = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CHECK: begin
        w_we = w_valid;
        w_done_nxt = w_valid;
        w_err_nxt = !w_valid;
        w_cnt_nxt = '0;
        w_state_nxt = bus.load_en ? ST_WAIT_LOW : ST_IDLE;
      end
      ST_WAIT_LOW: begin
        if (!bus.load_en)
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  bn_param_table #(
    .NEURONS(NEURONS),
    .ADDR_WIDTH(ADDR_WIDTH),
    .ADDEND_WIDTH(ADDEND_WIDTH)
  ) u_table (
    .clk(clk),
    .reset(reset),
    .i_we(w_we),
    .i_waddr(w_addr),
    .i_wfactor(w_factor),
    .i_waddend(w_addend),
    .i_raddr(bus.rd_addr),
    .o_rfactor(bus.bn_factor),
    .o_raddend(bus.bn_addend)
  );

  assign bus.busy = (r_state == ST_SHIFT) || (r_state == ST_CHECK);
  assign bus.load_done = r_done;
  assign bus.load_error = r_err;

endmodule

// File: tb/tb_bn_param_loader.sv
// Directed bench for bn_param_loader: frame
// commit, rejection, abort, reset and hold-high.
module tb_bn_param_loader;

  logic clk;
  logic reset;
  int total;
  int bad;

  logic [3:0] exp_f [4];
  logic [4:0] exp_a [4];

  bn_param_loader_if #(.ADDR_WIDTH(2), .ADDEND_WIDTH(5)) bus ();

  bn_param_loader #(
    .NEURONS(4),
    .ADDR_WIDTH(2),
    .ADDEND_WIDTH(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] mk(
    input logic [1:0] a,
    input logic [3:0] f,
    input logic [4:0] d
  );
    return {a, f, d};
  endfunction

  task automatic drive_bits(input logic [10:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      bus.load_en = 1'b1;
      bus.load_data = v[10-i];
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_identity();
    for (int i = 0; i < 4; i++) begin
      exp_f[i] = 4'b0100;
      exp_a[i] = 5'b00000;
    end
  endtask

  task automatic test_reset();
    set_identity();
    for (int i = 0; i < 4; i++) begin
      bus.rd_addr = 2'(i);
      #1;
      total++;
      if (bus.bn_factor !== exp_f[i] || bus.bn_addend !== exp_a[i]) begin
        bad++;
        $display("FAIL reset_entry%0d: got %b/%b want %b/%b",
                 i, bus.bn_factor, bus.bn_addend, exp_f[i], exp_a[i]);
      end
    end
    total++;
    if ({bus.busy, bus.load_done, bus.load_error} !== 3'b000) begin
      bad++;
      $display("FAIL reset_status: got %b want 000",
               {bus.busy, bus.load_done, bus.load_error});
    end
  endtask

  task automatic test_valid_frame();
    logic [10:0] v;
    int nb;
    v = mk(2'd2, 4'b0110, 5'b11101);
    nb = 0;
    for (int i = 0; i < 11; i++) begin
      bus.load_en = 1'b1;
      bus.load_data = v[10-i];
      @(posedge clk);
      #1;
      if (bus.busy) nb++;
    end
    bus.load_en = 1'b0;
    bus.rd_addr = 2'd2;
    #1;
    total++;
    if (bus.bn_factor !== 4'b0100 || bus.load_done !== 1'b0) begin
      bad++;
      $display("FAIL valid_pre_write: got f=%b done=%b want 0100/0",
               bus.bn_factor, bus.load_done);
    end
    @(posedge clk);
    #1;
    if (bus.busy) nb++;
    exp_f[2] = 4'b0110;
    exp_a[2] = 5'b11101;
    total++;
    if (bus.load_done !== 1'b1 || bus.load_error !== 1'b0) begin
      bad++;
      $display("FAIL valid_pulse: got done=%b err=%b want 1/0",
               bus.load_done, bus.load_error);
    end
    total++;
    if (nb !== 11) begin
      bad++;
      $display("FAIL valid_busy_cycles: got %0d want 11", nb);
    end
    for (int i = 0; i < 4; i++) begin
      bus.rd_addr = 2'(i);
      #1;
      total++;
      if (bus.bn_factor !== exp_f[i] || bus.bn_addend !== exp_a[i]) begin
        bad++;
        $display("FAIL valid_entry%0d: got %b/%b want %b/%b",
                 i, bus.bn_factor, bus.bn_addend, exp_f[i], exp_a[i]);
      end
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.load_done !== 1'b0) begin
      bad++;
      $display("FAIL valid_pulse_width: got done=%b want 0", bus.load_done);
    end
  endtask

  task automatic test_x8();
    drive_bits(mk(2'd1, 4'b0011, 5'b00001), 11);
    bus.load_en = 1'b0;
    @(posedge clk);
    #1;
    bus.rd_addr = 2'd1;
    #1;
    total++;
    if (bus.load_error !== 1'b1 || bus.load_done !== 1'b0 ||
        bus.bn_factor !== 4'b0100 || bus.bn_addend !== 5'b00000) begin
      bad++;
      $display("FAIL x8_nonzero: got err=%b done=%b e1=%b/%b want 1/0 0100/00000",
               bus.load_error, bus.load_done, bus.bn_factor, bus.bn_addend);
    end
    @(posedge clk);
    #1;
    drive_bits(mk(2'd1, 4'b0011, 5'b00000), 11);
    bus.load_en = 1'b0;
    @(posedge clk);
    #1;
    exp_f[1] = 4'b0011;
    exp_a[1] = 5'b00000;
    total++;
    if (bus.load_done !== 1'b1 || bus.load_error !== 1'b0 ||
        bus.bn_factor !== exp_f[1] || bus.bn_addend !== exp_a[1]) begin
      bad++;
      $display("FAIL x8_zero: got done=%b err=%b e1=%b/%b want 1/0 0011/00000",
               bus.load_done, bus.load_error, bus.bn_factor, bus.bn_addend);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_invalid_codes();
    logic [3:0] codes [2];
    codes[0] = 4'b1111;
    codes[1] = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      drive_bits(mk(2'd0, codes[k], 5'b00101), 11);
      bus.load_en = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if (bus.load_error !== 1'b1 || bus.load_done !== 1'b0) begin
        bad++;
        $display("FAIL invalid_%b: got err=%b done=%b want 1/0",
                 codes[k], bus.load_error, bus.load_done);
      end
      for (int i = 0; i < 4; i++) begin
        bus.rd_addr = 2'(i);
        #1;
        total++;
        if (bus.bn_factor !== exp_f[i] || bus.bn_addend !== exp_a[i]) begin
          bad++;
          $display("FAIL invalid_%b_entry%0d: got %b/%b want %b/%b",
                   codes[k], i, bus.bn_factor, bus.bn_addend,
                   exp_f[i], exp_a[i]);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_abort();
    drive_bits(mk(2'd0, 4'b0101, 5'b01010), 6);
    bus.load_en = 1'b0;
    @(posedge clk);
    #1;
    bus.rd_addr = 2'd0;
    #1;
    total++;
    if (bus.load_error !== 1'b1 || bus.load_done !== 1'b0 ||
        bus.busy !== 1'b0 || bus.bn_factor !== exp_f[0]) begin
      bad++;
      $display("FAIL abort: got err=%b done=%b busy=%b f0=%b want 1/0/0/%b",
               bus.load_error, bus.load_done, bus.busy,
               bus.bn_factor, exp_f[0]);
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.load_error !== 1'b0) begin
      bad++;
      $display("FAIL abort_pulse_width: got err=%b want 0", bus.load_error);
    end
    drive_bits(mk(2'd3, 4'b0101, 5'b00111), 11);
    bus.load_en = 1'b0;
    @(posedge clk);
    #1;
    exp_f[3] = 4'b0101;
    exp_a[3] = 5'b00111;
    bus.rd_addr = 2'd3;
    #1;
    total++;
    if (bus.load_done !== 1'b1 || bus.bn_factor !== exp_f[3] ||
        bus.bn_addend !== exp_a[3]) begin
      bad++;
      $display("FAIL after_abort: got done=%b e3=%b/%b want 1 0101/00111",
               bus.load_done, bus.bn_factor, bus.bn_addend);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_frame();
    drive_bits(mk(2'd0, 4'b1000, 5'b00011), 5);
    #2;
    reset = 1'b1;
    #1;
    set_identity();
    total++;
    if ({bus.busy, bus.load_done, bus.load_error} !== 3'b000) begin
      bad++;
      $display("FAIL midreset_status: got %b want 000",
               {bus.busy, bus.load_done, bus.load_error});
    end
    for (int i = 0; i < 4; i++) begin
      bus.rd_addr = 2'(i);
      #1;
      total++;
      if (bus.bn_factor !== exp_f[i] || bus.bn_addend !== exp_a[i]) begin
        bad++;
        $display("FAIL midreset_entry%0d: got %b/%b want %b/%b",
                 i, bus.bn_factor, bus.bn_addend, exp_f[i], exp_a[i]);
      end
    end
    bus.load_en = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_hold_high();
    logic [10:0] v;
    int nd;
    int ne;
    v = mk(2'd0, 4'b1000, 5'b10000);
    nd = 0;
    ne = 0;
    for (int i = 0; i < 15; i++) begin
      bus.load_en = 1'b1;
      bus.load_data = (i < 11) ? v[10-i] : 1'b1;
      @(posedge clk);
      #1;
      if (bus.load_done) nd++;
      if (bus.load_error) ne++;
    end
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL hold_wait_low_busy: got %b want 0", bus.busy);
    end
    bus.load_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      if (bus.load_done) nd++;
      if (bus.load_error) ne++;
    end
    exp_f[0] = 4'b1000;
    exp_a[0] = 5'b10000;
    total++;
    if (nd !== 1 || ne !== 0) begin
      bad++;
      $display("FAIL hold_pulses: got done=%0d err=%0d want 1/0", nd, ne);
    end
    bus.rd_addr = 2'd0;
    #1;
    total++;
    if (bus.bn_factor !== exp_f[0] || bus.bn_addend !== exp_a[0]) begin
      bad++;
      $display("FAIL hold_entry0: got %b/%b want 1000/10000",
               bus.bn_factor, bus.bn_addend);
    end
    drive_bits(mk(2'd2, 4'b0001, 5'b01111), 11);
    bus.load_en = 1'b0;
    @(posedge clk);
    #1;
    exp_f[2] = 4'b0001;
    exp_a[2] = 5'b01111;
    bus.rd_addr = 2'd2;
    #1;
    total++;
    if (bus.load_done !== 1'b1 || bus.bn_factor !== exp_f[2] ||
        bus.bn_addend !== exp_a[2]) begin
      bad++;
      $display("FAIL hold_next_frame: got done=%b e2=%b/%b want 1 0001/01111",
               bus.load_done, bus.bn_factor, bus.bn_addend);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    bus.load_en = 1'b0;
    bus.load_data = 1'b0;
    bus.rd_addr = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_valid_frame();
    test_x8();
    test_invalid_codes();
    test_abort();
    test_reset_mid_frame();
    test_hold_high();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
